// File: rtl/stopwatch_counter_if.sv
// rtl/stopwatch_counter_if.sv - control/display bundle for the stopwatch counter
//
// Purpose: groups the tick/control requests and the BCD display outputs of
// stopwatch_counter into one bundle.
// Ports (members):
//   i_TICK, i_START, i_STOP, i_CLEAR : requests into the counter
//   o_SEC_ONES, o_SEC_TENS           : BCD seconds digits
//   o_MIN_ONES, o_MIN_TENS           : BCD minutes digits
//   o_RUNNING                        : counter is in RUN
//   o_WRAP                           : one-cycle pulse on MAX_MIN:59 -> 00:00
// Modports: master drives requests and watches the display, slave is the counter.

interface stopwatch_counter_if;
    logic       i_TICK;
    logic       i_START;
    logic       i_STOP;
    logic       i_CLEAR;
    logic [3:0] o_SEC_ONES;
    logic [3:0] o_SEC_TENS;
    logic [3:0] o_MIN_ONES;
    logic [3:0] o_MIN_TENS;
    logic       o_RUNNING;
    logic       o_WRAP;

    modport master (
        output i_TICK, i_START, i_STOP, i_CLEAR,
        input  o_SEC_ONES, o_SEC_TENS, o_MIN_ONES, o_MIN_TENS, o_RUNNING, o_WRAP
    );

    modport slave (
        input  i_TICK, i_START, i_STOP, i_CLEAR,
        output o_SEC_ONES, o_SEC_TENS, o_MIN_ONES, o_MIN_TENS, o_RUNNING, o_WRAP
    );
endinterface

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - tick-driven BCD minutes:seconds stopwatch
//
// Purpose: counts rising edges of a divider square wave as seconds while
// running, in BCD, wrapping MAX_MIN:59 -> 00:00. Controlled by START/STOP/CLEAR
// with priority CLEAR > STOP > START.
// Ports:
//   i_CLK : system clock
//   i_RST : asynchronous active-low reset
//   bus   : stopwatch_counter_if.slave (requests in, BCD digits/status out)
// Parameter:
//   MAX_MIN : highest minutes value, 1..99

module stopwatch_counter #(
    parameter int MAX_MIN = 59
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    stopwatch_counter_if.slave   bus
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t     state;
    logic       tick_d;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;

    logic       evt;
    logic       at_max;

    // i_TICK is already synchronous to i_CLK, so a single delay register is
    // enough for the rising-edge detect.
    assign evt    = bus.i_TICK & ~tick_d;
    assign at_max = (min_tens == MAX_TENS) && (min_ones == MAX_ONES) &&
                    (sec_tens == 4'd5) && (sec_ones == 4'd9);

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state    <= IDLE;
            tick_d   <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            running  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            // Tracks i_TICK in every state so a paused edge is never counted late.
            tick_d <= bus.i_TICK;
            wrap   <= 1'b0;

            if (bus.i_CLEAR) begin
                state    <= IDLE;
                running  <= 1'b0;
                sec_ones <= 4'd0;
                sec_tens <= 4'd0;
                min_ones <= 4'd0;
                min_tens <= 4'd0;
            end else begin
                // Counting looks at the current state: an edge coinciding with
                // STOP still counts, one coinciding with START does not.
                if (state == RUN && evt) begin
                    if (at_max) begin
                        sec_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        min_ones <= 4'd0;
                        min_tens <= 4'd0;
                        wrap     <= 1'b1;
                    end else if (sec_ones != 4'd9) begin
                        sec_ones <= sec_ones + 4'd1;
                    end else begin
                        sec_ones <= 4'd0;
                        if (sec_tens != 4'd5) begin
                            sec_tens <= sec_tens + 4'd1;
                        end else begin
                            sec_tens <= 4'd0;
                            if (min_ones != 4'd9) begin
                                min_ones <= min_ones + 4'd1;
                            end else begin
                                min_ones <= 4'd0;
                                min_tens <= min_tens + 4'd1;
                            end
                        end
                    end
                end

                case (state)
                    RUN: begin
                        if (bus.i_STOP) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    IDLE, PAUSE: begin
                        if (bus.i_START) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_SEC_ONES = sec_ones;
    assign bus.o_SEC_TENS = sec_tens;
    assign bus.o_MIN_ONES = min_ones;
    assign bus.o_MIN_TENS = min_tens;
    assign bus.o_RUNNING  = running;
    assign bus.o_WRAP     = wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - self-checking bench for stopwatch_counter

module tb_stopwatch_counter;

    logic clk;
    logic rst_n;

    stopwatch_counter_if ifa ();
    stopwatch_counter_if ifb ();

    stopwatch_counter dut_a (
        .i_CLK (clk),
        .i_RST (rst_n),
        .bus   (ifa.slave)
    );

    stopwatch_counter #(.MAX_MIN(2)) dut_b (
        .i_CLK (clk),
        .i_RST (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed seconds as a plain integer per instance.
    int secs_a, secs_b;
    bit m_run, m_prev, m_wrap_a, m_wrap_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] digits_a();
        return {ifa.o_MIN_TENS, ifa.o_MIN_ONES, ifa.o_SEC_TENS, ifa.o_SEC_ONES};
    endfunction

    function automatic logic [15:0] digits_b();
        return {ifb.o_MIN_TENS, ifb.o_MIN_ONES, ifb.o_SEC_TENS, ifb.o_SEC_ONES};
    endfunction

    task automatic model_reset();
        secs_a = 0; secs_b = 0;
        m_run = 0; m_prev = 0; m_wrap_a = 0; m_wrap_b = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit p, input bit c);
        bit evt;
        evt = t && !m_prev;
        m_wrap_a = 0;
        m_wrap_b = 0;
        if (c) begin
            secs_a = 0;
            secs_b = 0;
            m_run  = 0;
        end else begin
            if (m_run && evt) begin
                secs_a   = (secs_a + 1) % (60 * 60);
                secs_b   = (secs_b + 1) % (3 * 60);
                m_wrap_a = (secs_a == 0);
                m_wrap_b = (secs_b == 0);
            end
            if (m_run) begin
                if (p) m_run = 0;
            end else if (s) begin
                m_run = 1;
            end
        end
        m_prev = t;
    endtask

    task automatic drive(input bit t, input bit s, input bit p, input bit c);
        ifa.i_TICK = t; ifa.i_START = s; ifa.i_STOP = p; ifa.i_CLEAR = c;
        ifb.i_TICK = t; ifb.i_START = s; ifb.i_STOP = p; ifb.i_CLEAR = c;
    endtask

    // One clock: drive at negedge, step the model at posedge, compare at next negedge.
    task automatic cycle(input bit t, input bit s, input bit p, input bit c);
        drive(t, s, p, c);
        @(posedge clk);
        model_step(t, s, p, c);
        @(negedge clk);
        check("state_a", {14'd0, digits_a(), ifa.o_RUNNING, ifa.o_WRAP},
              {14'd0, to_bcd(secs_a), m_run, m_wrap_a});
        check("state_b", {14'd0, digits_b(), ifb.o_RUNNING, ifb.o_WRAP},
              {14'd0, to_bcd(secs_b), m_run, m_wrap_b});
    endtask

    task automatic edges(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            for (int h = 0; h < hi; h++) cycle(1, 0, 0, 0);
            for (int l = 0; l < lo; l++) cycle(0, 0, 0, 0);
        end
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        model_reset();
        check("async_rst_a", {14'd0, digits_a(), ifa.o_RUNNING, ifa.o_WRAP}, 32'd0);
        check("async_rst_b", {14'd0, digits_b(), ifb.o_RUNNING, ifb.o_WRAP}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit t;
        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset_a", {14'd0, digits_a(), ifa.o_RUNNING, ifa.o_WRAP}, 32'd0);
        check("reset_b", {14'd0, digits_b(), ifb.o_RUNNING, ifb.o_WRAP}, 32'd0);
        rst_n = 1'b1;

        // 1. start and count, then asynchronous reset mid-count
        cycle(0, 1, 0, 0);
        edges(5, 2, 2);
        check("count5", {digits_a(), 15'd0, ifa.o_RUNNING}, {16'h0005, 15'd0, 1'b1});
        edges(2, 1, 1);
        async_reset();
        edges(3, 2, 2);
        check("no_count_after_rst", {digits_a(), 15'd0, ifa.o_RUNNING}, 32'd0);

        // 2. BCD carries
        cycle(0, 1, 0, 0);
        edges(60, 2, 2);
        check("carry_0100", digits_a(), 16'h0100);
        edges(9, 2, 2);
        check("carry_0109", digits_a(), 16'h0109);
        edges(1, 2, 2);
        check("carry_0110", digits_a(), 16'h0110);

        // 3. wrap on the MAX_MIN=2 instance at minimum tick spacing
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        edges(179, 1, 1);
        check("pre_wrap_b", digits_b(), 16'h0259);
        cycle(1, 0, 0, 0);
        check("wrap_b", {digits_b(), 14'd0, ifb.o_RUNNING, ifb.o_WRAP}, {16'h0000, 14'd0, 1'b1, 1'b1});
        check("no_wrap_a", {digits_a(), 15'd0, ifa.o_WRAP}, {16'h0300, 16'd0});
        cycle(0, 0, 0, 0);
        check("wrap_one_cycle", {31'd0, ifb.o_WRAP}, 32'd0);

        // 4. pause/resume and same-cycle START/STOP with an edge
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        edges(3, 2, 2);
        cycle(0, 0, 1, 0);
        edges(4, 2, 2);
        check("pause_hold", {digits_a(), 15'd0, ifa.o_RUNNING}, {16'h0003, 16'd0});
        cycle(0, 1, 0, 0);
        edges(2, 2, 2);
        check("resume", digits_a(), 16'h0005);
        cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("start_evt_not_counted", {digits_a(), 15'd0, ifa.o_RUNNING}, {16'h0005, 15'd0, 1'b1});
        cycle(1, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check("stop_evt_counted", {digits_a(), 15'd0, ifa.o_RUNNING}, {16'h0006, 16'd0});

        // 5. CLEAR beats STOP and START
        cycle(0, 1, 0, 0);
        edges(1, 2, 2);
        check("at_0007", digits_a(), 16'h0007);
        cycle(1, 1, 1, 1);
        check("priority_clear", {digits_a(), 15'd0, ifa.o_RUNNING}, 32'd0);
        cycle(0, 0, 0, 0);

        // 6. held tick counts once; 100 edges at divider ratio 2
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("held_tick", digits_a(), 16'h0001);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 0);
        edges(100, 2, 2);
        check("ratio2_100", digits_a(), 16'h0140);

        // Randomized mix against the reference model
        t = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2, 0) == 0) t = ~t;
            cycle(t,
                  $urandom_range(7, 0) == 0,
                  $urandom_range(23, 0) == 0,
                  $urandom_range(299, 0) == 0);
            if ($urandom_range(999, 0) == 0) begin
                async_reset();
                t = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Tick-driven BCD minutes:seconds stopwatch with start/stop/clear control. Sits directly downstream of the clock divider: the divider's square-wave output drives `i_TICK`, and each rising edge of `i_TICK` advances the count by one second while running. The BCD digits feed the display-scan stage.

## Interface
- `MAX_MIN`, default 59: highest minutes value (legal range 1..99). The count wraps from MAX_MIN:59 to 00:00.
- `i_CLK`  in  1  system clock. Same clock that drives the divider.
- `i_RST`  in  1  reset, asynchronous, active-low. Clears all state and outputs.
- `i_TICK`  in  1  square wave from the divider, synchronous to `i_CLK`. Each 0→1 transition is one count event.
- `i_START`  in  1  start/resume request, sampled each cycle.
- `i_STOP`  in  1  pause request, sampled each cycle.
- `i_CLEAR`  in  1  clear request, sampled each cycle.
- `o_SEC_ONES`  out  4  BCD seconds units, 0..9.
- `o_SEC_TENS`  out  4  BCD seconds tens, 0..5.
- `o_MIN_ONES`  out  4  BCD minutes units, 0..9.
- `o_MIN_TENS`  out  4  BCD minutes tens, 0..9.
- `o_RUNNING`  out  1  high while the FSM is in RUN.
- `o_WRAP`  out  1  one-cycle pulse when the count wraps to 00:00.

## Operation
- **Edge detect.** A register `tick_d` holds the previous `i_TICK`. It resets to 0. The count event is `evt = i_TICK & ~tick_d`. `i_TICK` is already synchronous, so there is no synchronizer.
- **FSM states:** IDLE, RUN, PAUSE. Reset state is IDLE.
- **Request priority per cycle:** CLEAR > STOP > START.
  - CLEAR in any state → IDLE, and all digits go to 0.
  - STOP in RUN → PAUSE. STOP in IDLE or PAUSE has no effect.
  - START in IDLE or PAUSE → RUN. START in RUN has no effect.
- **Counting uses the current state, not the next state.** On an edge where state = RUN, `evt` = 1 and CLEAR = 0, the count increments.
  - START and `evt` in the same cycle from IDLE/PAUSE: not counted.
  - STOP and `evt` in the same cycle in RUN: counted.
- **Increment (BCD ripple):**
  - sec_ones 9 → 0 with carry into sec_tens.
  - sec_tens 5 → 0 with carry into minutes.
  - Minutes are kept as two BCD digits: min_ones 9 → 0 with carry into min_tens.
- **Wrap.** When the value is MAX_MIN:59, the increment sets all digits to 0 and `o_WRAP` = 1 for that one cycle. The FSM stays in RUN.
- **PAUSE** holds the digits. `tick_d` keeps tracking `i_TICK` in every state, so an edge that occurred while paused is never counted late.
- **Outputs** are registers. No combinational path exists from any input to any output.

## Timing
- **Reset** (`i_RST` = 0, asynchronous): all digits 0, `o_RUNNING` = 0, `o_WRAP` = 0, `tick_d` = 0, state IDLE. Release is taken synchronously at the next `i_CLK` edge.
- **Reset mid-count:** outputs clear immediately, without waiting for a clock edge. After release, counting restarts only after a new START.
- **Count latency.** If `i_TICK` goes 0→1 before edge N, the digits show the new value after edge N (one cycle).
- **Held `i_TICK`.** `i_TICK` held high for k cycles counts once.
- **Minimum tick spacing** is 2 cycles (divider ratio 2 gives a 0→1 transition every 4 cycles). Every edge is counted.
- **Control latency.** START/STOP/CLEAR change state, and `o_RUNNING`, after 1 cycle.
- **Wrap pulse.** `o_WRAP` is high for exactly the one cycle following the wrap edge.

## Test plan
1. **Reset, start, count.** Assert `i_RST` = 0, release, pulse START, apply 5 `i_TICK` rising edges → digits 00:05, `o_RUNNING` = 1. Asserting `i_RST` = 0 mid-cycle clears the outputs asynchronously.
2. **BCD carry.** Start from 00:00 and apply 60 edges → 01:00. Apply 9 more edges to reach 01:09, then 1 more → 01:10. `sec_tens` never exceeds 5.
3. **Wrap** (`MAX_MIN` = 2). Apply 179 edges → 02:59. The next edge gives 00:00, `o_WRAP` high for exactly 1 cycle, `o_RUNNING` still 1.
4. **Pause/resume.**
   - At 00:03, STOP → 4 edges arrive → digits stay 00:03.
   - START → 2 edges → 00:05.
   - START and an edge in the same cycle → that edge is not counted.
   - STOP and an edge in the same cycle → that edge is counted.
5. **Priority.** At 00:07 in RUN, assert CLEAR, STOP and START together with an edge → IDLE, 00:00, `o_RUNNING` = 0.
6. **Held tick.** Hold `i_TICK` = 1 for 10 cycles in RUN → count advances by exactly 1. With divider ratio 2 (period 4 cycles), 100 edges → 01:40.
